window_gen: RTL and testbench

WINDOW_GEN -- requirements
Module: window_gen

---
 rtl/window_gen_pkg.sv | 18 +
 rtl/window_gen_if.sv | 38 +++
 rtl/line_buffer.sv | 29 ++
 rtl/window_gen.sv | 136 +++++++++++++
 tb/tb_window_gen.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/window_gen_pkg.sv
// Shared image-pipeline definitions: pixel width, default frame size and the
// window generator FSM state encoding.
package window_gen_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned IMG_W_DEF = 64;
    localparam int unsigned IMG_H_DEF = 64;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/window_gen_if.sv
// Pixel stream in / 3x3 window out bundle for the window generator.
//   master : pixel source and filter side (drives en, pix_valid, pix_in)
//   slave  : window_gen (drives sw_pixels1..9, act, frame_done)
interface window_gen_if;
    import window_gen_pkg::*;

    logic en;
    logic pix_valid;
    pix_t pix_in;
    pix_t sw_pixels1;
    pix_t sw_pixels2;
    pix_t sw_pixels3;
    pix_t sw_pixels4;
    pix_t sw_pixels5;
    pix_t sw_pixels6;
    pix_t sw_pixels7;
    pix_t sw_pixels8;
    pix_t sw_pixels9;
    logic act;
    logic frame_done;

    modport master (
        output en, pix_valid, pix_in,
        input  sw_pixels1, sw_pixels2, sw_pixels3,
        input  sw_pixels4, sw_pixels5, sw_pixels6,
        input  sw_pixels7, sw_pixels8, sw_pixels9,
        input  act, frame_done
    );

    modport slave (
        input  en, pix_valid, pix_in,
        output sw_pixels1, sw_pixels2, sw_pixels3,
        output sw_pixels4, sw_pixels5, sw_pixels6,
        output sw_pixels7, sw_pixels8, sw_pixels9,
        output act, frame_done
    );

endinterface

// File: rtl/line_buffer.sv
// Single-line pixel store for the window generator.
//   clk   : write clock
//   we    : write enable
//   addr  : shared read/write address (column)
//   wdata : write data
//   rdata : combinational read of addr, returns the value before this write
// Contents are intentionally not reset; the frame fill overwrites them.
module line_buffer #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : en / pix_valid / pix_in in; sw_pixels1..9 (row-major window),
//              act (window valid, 1 cycle after the pixel) and frame_done out
module window_gen
    import window_gen_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF
) (
    input  logic         clk,
    input  logic         rst,
    window_gen_if.slave  bus
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    pix_t             win [9];
    logic             act;
    logic             frame_done;
    pix_t             lb0_rd;
    pix_t             lb1_rd;
    logic             accept;
    logic             col_last;
    logic             row_last;

    // en low in FILL/RUN aborts, so a pixel in that cycle is dropped
    assign accept   = bus.pix_valid && bus.en && ((state == FILL) || (state == RUN));
    assign col_last = (col == COL_W'(IMG_W - 1));
    assign row_last = (row == ROW_W'(IMG_H - 1));

    // lb0 holds row-1, lb1 holds row-2; lb1 takes lb0's old value at col
    line_buffer #(.DEPTH(IMG_W), .DATA_W(PIX_W)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (bus.pix_in),
        .rdata (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .DATA_W(PIX_W)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    // Frame FSM with raster counters and registered strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            act        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            act        <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        state <= FILL;
                    end
                end
                FILL, RUN: begin
                    if (!bus.en) begin
                        state <= IDLE;
                        row   <= '0;
                        col   <= '0;
                    end else if (accept) begin
                        act <= (row >= ROW_W'(2)) && (col >= COL_W'(2));
                        if (col_last) begin
                            col <= '0;
                            row <= row + ROW_W'(1);
                        end else begin
                            col <= col + COL_W'(1);
                        end
                        if ((state == FILL) && (row == ROW_W'(2)) && (col == '0)) begin
                            state <= RUN;
                        end
                        if ((state == RUN) && row_last && col_last) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                            row        <= '0;
                            col        <= '0;
                        end
                    end
                end
                // Going straight to FILL keeps the next frame's first pixel
                DONE: begin
                    state <= bus.en ? FILL : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Window shifts left on each accepted pixel, new column enters on the right
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
        end else if (accept) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= lb1_rd;
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= lb0_rd;
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= bus.pix_in;
        end
    end

    assign bus.sw_pixels1 = win[0];
    assign bus.sw_pixels2 = win[1];
    assign bus.sw_pixels3 = win[2];
    assign bus.sw_pixels4 = win[3];
    assign bus.sw_pixels5 = win[4];
    assign bus.sw_pixels6 = win[5];
    assign bus.sw_pixels7 = win[6];
    assign bus.sw_pixels8 = win[7];
    assign bus.sw_pixels9 = win[8];
    assign bus.act        = act;
    assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_window_gen.sv
// Directed and randomized checks of window_gen on a 4x4 image against a
// frame-image reference model.
module tb_window_gen;
    import window_gen_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    window_gen_if bus ();

    window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    byte unsigned img [H][W];
    int          r, c;
    bit          live;
    logic [71:0] last_win;
    bit          last_known;
    int          act_obs, done_obs;

    function automatic logic [71:0] obs_win();
        return {bus.sw_pixels1, bus.sw_pixels2, bus.sw_pixels3,
                bus.sw_pixels4, bus.sw_pixels5, bus.sw_pixels6,
                bus.sw_pixels7, bus.sw_pixels8, bus.sw_pixels9};
    endfunction

    // Window centred on (rr-1, cc-1) taken straight from the stored image
    function automatic logic [71:0] model_win(input int rr, input int cc);
        logic [71:0] w;
        w = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w = {w[63:0], img[rr-2+dr][cc-2+dc]};
        return w;
    endfunction

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus, with the model predicting the outputs after the edge
    task automatic cyc(input bit en_v, input bit valid, input byte unsigned v);
        bit          acc, exp_act, exp_done;
        logic [71:0] exp_w;
        bus.en        = en_v;
        bus.pix_valid = valid;
        bus.pix_in    = v;
        acc      = en_v && valid && live;
        exp_act  = 1'b0;
        exp_done = 1'b0;
        exp_w    = last_win;
        if (acc) begin
            img[r][c] = v;
            exp_act   = (r >= 2) && (c >= 2);
            if (exp_act) exp_w = model_win(r, c);
            exp_done  = (r == H-1) && (c == W-1);
            c++;
            if (c == W) begin
                c = 0;
                r++;
            end
        end
        if (!en_v || exp_done) begin
            live = 1'b0;
            r    = 0;
            c    = 0;
        end else begin
            live = 1'b1;
        end
        @(posedge clk);
        #1;
        check("act", 72'(bus.act), 72'(exp_act));
        check("frame_done", 72'(bus.frame_done), 72'(exp_done));
        if (exp_act) begin
            check("window", obs_win(), exp_w);
            last_win   = exp_w;
            last_known = 1'b1;
        end else if (acc) begin
            last_known = 1'b0;
        end else if (last_known) begin
            check("hold_window", obs_win(), last_win);
        end
        if (bus.act === 1'b1) act_obs++;
        if (bus.frame_done === 1'b1) done_obs++;
    endtask

    task automatic reset_outputs_check(input string tag);
        check({tag, "_act"}, 72'(bus.act), 72'd0);
        check({tag, "_done"}, 72'(bus.frame_done), 72'd0);
        check({tag, "_window"}, obs_win(), 72'd0);
        check({tag, "_rowcol"}, 72'({dut.row, dut.col}), 72'd0);
    endtask

    // Reset asserted between clock edges; outputs must clear before the next edge
    task automatic do_reset();
        bus.en        = 1'b0;
        bus.pix_valid = 1'b0;
        rst           = 1'b1;
        #2;
        reset_outputs_check("async_reset");
        @(posedge clk);
        #1;
        rst        = 1'b0;
        live       = 1'b0;
        r          = 0;
        c          = 0;
        last_win   = '0;
        last_known = 1'b1;
    endtask

    // rnd: random pixels and gaps; otherwise value = 4*row+col, gaps every other cycle
    task automatic run_frame(input bit rnd, input bit gaps, input int abort_after);
        byte unsigned v;
        act_obs  = 0;
        done_obs = 0;
        cyc(1'b1, 1'b0, 8'd0);
        for (int p = 0; p < W*H; p++) begin
            v = rnd ? 8'($urandom) : 8'(p);
            cyc(1'b1, 1'b1, v);
            if (!rnd && p == 10)
                check("first_window", obs_win(), 72'h00_01_02_04_05_06_08_09_0A);
            if (!rnd && p == 15) begin
                check("last_window", obs_win(), 72'h05_06_07_09_0A_0B_0D_0E_0F);
                check("last_frame_done", 72'(bus.frame_done), 72'd1);
            end
            if (p == abort_after) begin
                cyc(1'b0, 1'b1, 8'd12);
                repeat (3) cyc(1'b0, 1'b0, 8'd0);
                check("abort_act_count", 72'(act_obs), 72'd2);
                check("abort_done_count", 72'(done_obs), 72'd0);
                return;
            end
            if (gaps) begin
                if (rnd) repeat ($urandom_range(0, 2)) cyc(1'b1, 1'b0, 8'($urandom));
                else cyc(1'b1, 1'b0, 8'hAA);
            end
        end
        check("frame_act_count", 72'(act_obs), 72'(4));
        check("frame_done_count", 72'(done_obs), 72'd1);
    endtask

    initial begin
        int tot_act, tot_done;
        bus.en        = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        rst           = 1'b1;
        live          = 1'b0;
        r             = 0;
        c             = 0;
        last_win      = '0;
        last_known    = 1'b1;
        act_obs       = 0;
        done_obs      = 0;
        #12;
        reset_outputs_check("power_on_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle: pixels without en are ignored
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 8'($urandom));
        check("idle_rowcol", 72'({dut.row, dut.col}), 72'd0);

        // Basic frame, then return to idle
        run_frame(1'b0, 1'b0, -1);
        cyc(1'b0, 1'b0, 8'd0);

        // Alternating gaps
        run_frame(1'b0, 1'b1, -1);
        cyc(1'b0, 1'b0, 8'd0);

        // Abort after pixel 11, then a clean frame
        run_frame(1'b0, 1'b0, 11);
        run_frame(1'b0, 1'b0, -1);
        cyc(1'b0, 1'b0, 8'd0);

        // Reset mid-frame after pixel 6, then a clean frame
        cyc(1'b1, 1'b0, 8'd0);
        for (int p = 0; p <= 6; p++) cyc(1'b1, 1'b1, 8'(p));
        do_reset();
        run_frame(1'b0, 1'b0, -1);
        cyc(1'b0, 1'b0, 8'd0);

        // Back-to-back frames with en held high, pix_valid low in DONE
        run_frame(1'b0, 1'b0, -1);
        tot_act  = act_obs;
        tot_done = done_obs;
        run_frame(1'b0, 1'b0, -1);
        tot_act  += act_obs;
        tot_done += done_obs;
        check("b2b_act_total", 72'(tot_act), 72'd8);
        check("b2b_done_total", 72'(tot_done), 72'd2);

        // Randomized back-to-back frames with random gaps
        for (int f = 0; f < 4; f++) run_frame(1'b1, 1'b1, -1);
        cyc(1'b0, 1'b0, 8'd0);
        repeat (3) cyc(1'b0, 1'b0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
